// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and helpers for the UART word transmitter
// and its receive-side counterpart.
package uart_pkg;

    localparam int DEF_NBITS      = 32;
    localparam int DEF_DBIT       = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_SB_TICK    = 16;
    localparam int BYTES_PER_WORD = DEF_NBITS / DEF_DBIT;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_WAIT
    } word_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_t;

    typedef struct packed {
        word_state_t word_state;
        byte_state_t byte_state;
    } tx_dbg_t;

    // Counter width that stays at least one bit for degenerate limits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Word-level transmit handshake between the debug controller and uart_word_tx.
interface uart_word_tx_if #(
    parameter int NBITS = uart_pkg::DEF_NBITS
);

    // tx_start/tx_Data form a request accepted on any rising clk edge where
    // tx_start=1 and tx_busy=0; tx_Data is captured on that edge only.
    // tx_busy stays high until the tx_done pulse, which lands in the first
    // cycle where tx_busy is low again. Requests while busy are dropped.
    logic             tx_start;
    logic [NBITS-1:0] tx_Data;
    logic             tx_done;
    logic             tx_busy;

    modport master (
        output tx_start,
        output tx_Data,
        input  tx_done,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_Data,
        output tx_done,
        output tx_busy
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1-style byte serialiser timed by an oversampled baud tick; drives a
// registered, glitch-free serial line and pulses byte_done after the stop bit.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int DBIT       = DEF_DBIT,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int SB_TICK    = DEF_SB_TICK
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            byte_start,
    input  logic [DBIT-1:0] byte_in,
    output logic            byte_done,
    output logic            tx,
    output byte_state_t     state
);

    localparam int TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int TW       = cnt_width(TICK_MAX);
    localparam int BW       = cnt_width(DBIT);

    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

    logic [TW-1:0]   tick_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [DBIT-1:0] shift_reg;
    logic [DBIT-1:0] shift_next;

    assign shift_next = shift_reg >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= B_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            case (state)
                B_IDLE: begin
                    if (byte_start) begin
                        shift_reg <= byte_in;
                        tick_cnt  <= '0;
                        bit_cnt   <= '0;
                        tx        <= 1'b0;
                        state     <= B_START;
                    end
                end
                // Every phase restarts its count at 0, so the tick that ends
                // one phase is never also counted by the next.
                B_START: begin
                    if (s_tick) begin
                        if (tick_cnt == OS_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            tx       <= shift_reg[0];
                            state    <= B_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                B_DATA: begin
                    if (s_tick) begin
                        if (tick_cnt == OS_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= shift_next;
                            if (bit_cnt == BIT_LAST) begin
                                tx    <= 1'b1;
                                state <= B_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                                tx      <= shift_next[0];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                B_STOP: begin
                    if (s_tick) begin
                        if (tick_cnt == SB_LAST) begin
                            tick_cnt  <= '0;
                            byte_done <= 1'b1;
                            state     <= B_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= B_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word transmitter: accepts an NBITS word and sends it LSB byte first as a
// sequence of UART frames through uart_tx_byte, then pulses tx_done.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int NBITS      = DEF_NBITS,
    parameter int DBIT       = DEF_DBIT,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_tick,
    uart_word_tx_if.slave  bus,
    output logic           tx,
    output tx_dbg_t        dbg
);

    localparam int BPW = NBITS / DBIT;
    localparam int CW  = cnt_width(BPW);

    localparam logic [CW-1:0] BYTE_LAST = CW'(BPW - 1);

    word_state_t     state;
    byte_state_t     byte_state;
    logic [CW-1:0]   byte_cnt;
    logic [NBITS-1:0] word_reg;
    logic            byte_start;
    logic [DBIT-1:0] byte_in;
    logic            byte_done;

    // SEND lasts one cycle, so the serialiser sees exactly one start pulse
    // and the inter-byte gap is SEND plus the serialiser's load edge.
    assign byte_start = (state == W_SEND);
    assign byte_in    = word_reg[byte_cnt*DBIT +: DBIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= W_IDLE;
            byte_cnt    <= '0;
            word_reg    <= '0;
            bus.tx_done <= 1'b0;
            bus.tx_busy <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            case (state)
                W_IDLE: begin
                    if (bus.tx_start) begin
                        word_reg    <= bus.tx_Data;
                        byte_cnt    <= '0;
                        bus.tx_busy <= 1'b1;
                        state       <= W_SEND;
                    end
                end
                W_SEND: begin
                    state <= W_WAIT;
                end
                W_WAIT: begin
                    if (byte_done) begin
                        if (byte_cnt == BYTE_LAST) begin
                            byte_cnt    <= '0;
                            bus.tx_done <= 1'b1;
                            bus.tx_busy <= 1'b0;
                            state       <= W_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                            state    <= W_SEND;
                        end
                    end
                end
                default: begin
                    bus.tx_busy <= 1'b0;
                    state       <= W_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .DBIT       (DBIT),
        .OVERSAMPLE (OVERSAMPLE),
        .SB_TICK    (SB_TICK)
    ) u_tx_byte (
        .clk        (clk),
        .rst        (rst),
        .s_tick     (s_tick),
        .byte_start (byte_start),
        .byte_in    (byte_in),
        .byte_done  (byte_done),
        .tx         (tx),
        .state      (byte_state)
    );

    assign dbg = '{word_state: state, byte_state: byte_state};

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: decodes the serial line mid-bit and
// compares bytes, framing, bit timing and handshake pulses against hand values.
module tb_uart_word_tx;
    import uart_pkg::*;

    localparam int NB = 32;

    logic    clk = 1'b0;
    logic    rst;
    logic    s_tick;
    logic    tx;
    tx_dbg_t dbg;

    uart_word_tx_if #(.NBITS(NB)) bus ();

    uart_word_tx #(.NBITS(NB)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_tick (s_tick),
        .bus    (bus),
        .tx     (tx),
        .dbg    (dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_pass     = 0;
    int tick_div   = 1;
    int tick_phase = 0;
    int done_cnt   = 0;
    int cyc        = 0;

    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tick_div <= 1) begin
            s_tick = 1'b1;
        end else begin
            tick_phase = (tick_phase + 1) % tick_div;
            s_tick     = (tick_phase == 0);
        end
        if (bus.tx_done === 1'b1) done_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // driver tasks
    task automatic send_word(input logic [31:0] w);
        @(negedge clk);
        bus.tx_start = 1'b1;
        bus.tx_Data  = w;
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_Data  = $urandom;
        check("busy after accept", {31'd0, bus.tx_busy}, 32'd1);
    endtask

    // Returns in the middle of the stop bit; inner_run is the length in clk
    // of the first low run that follows a high sample inside the frame.
    task automatic recv_byte(input int bit_clks, output logic [7:0] data,
                             output logic start_b, output logic stop_b,
                             output int inner_run, output int fall_cyc);
        int   waited;
        int   k;
        logic seen_one;
        logic in_run;
        logic run_done;
        waited    = 0;
        data      = '0;
        start_b   = 1'b1;
        stop_b    = 1'b0;
        inner_run = 0;
        seen_one  = 1'b0;
        in_run    = 1'b0;
        run_done  = 1'b0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < 4000);
        fall_cyc = cyc;
        check("start edge found", {31'd0, tx}, 32'd0);
        if (tx !== 1'b0) return;
        for (int c = 0; c <= 9*bit_clks + bit_clks/2; c++) begin
            if (c > 0) @(negedge clk);
            if (c % bit_clks == bit_clks/2) begin
                k = c / bit_clks;
                if (k == 0)      start_b   = tx;
                else if (k == 9) stop_b    = tx;
                else             data[k-1] = tx;
            end
            if (!run_done) begin
                if (seen_one && tx == 1'b0) begin
                    inner_run++;
                    in_run = 1'b1;
                end else if (in_run && tx == 1'b1) begin
                    run_done = 1'b1;
                end
                if (tx == 1'b1) seen_one = 1'b1;
            end
        end
    endtask

    // scoreboard: each decoded frame is compared with the head of exp_q
    task automatic rx_expect(input int bit_clks, output int inner_run, output int fall_cyc);
        logic [7:0] d;
        logic       sb;
        logic       pb;
        logic [7:0] e;
        recv_byte(bit_clks, d, sb, pb, inner_run, fall_cyc);
        check("expected byte queued", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check("decoded byte", {24'd0, d}, {24'd0, e});
        check("start bit level", {31'd0, sb}, 32'd0);
        check("stop bit level", {31'd0, pb}, 32'd1);
    endtask

    // Returns at the negedge inside the tx_done cycle.
    task automatic wait_done();
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.tx_done !== 1'b1 && waited < 400);
        check("tx_done pulse", {31'd0, bus.tx_done}, 32'd1);
        check("busy low in done cycle", {31'd0, bus.tx_busy}, 32'd0);
    endtask

    initial begin
        int ir;
        int fc;
        int d0;
        int bad;
        int done_c;
        int waited;

        rst          = 1'b0;
        s_tick       = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_Data  = '0;
        repeat (3) @(negedge clk);
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset busy", {31'd0, bus.tx_busy}, 32'd0);
        check("reset done", {31'd0, bus.tx_done}, 32'd0);
        check("reset word state", {30'd0, dbg.word_state}, {30'd0, W_IDLE});
        rst = 1'b1;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) bad++;
        end
        check("idle 1000 cycles", bad, 0);

        // word 1: s_tick every clk, bit period 16 clk
        d0 = done_cnt;
        send_word(32'h12345678);
        for (int i = 0; i < 4; i++) begin
            rx_expect(16, ir, fc);
            if (i == 0) check("0x78 bit7 low run", ir, 16);
        end
        wait_done();
        repeat (5) @(negedge clk);
        check("done count word1", done_cnt - d0, 1);

        // word 2: s_tick every 4 clk, bit period 64 clk
        tick_div = 4;
        d0 = done_cnt;
        send_word(32'hA5C3FF00);
        for (int i = 0; i < 4; i++) begin
            rx_expect(64, ir, fc);
            if (i == 2) check("0xC3 bits2-5 low run", ir, 256);
            if (i == 3) check("0xA5 bit1 low run", ir, 64);
        end
        wait_done();
        repeat (5) @(negedge clk);
        check("done count word2", done_cnt - d0, 1);
        tick_div = 1;

        // request while busy is dropped
        d0 = done_cnt;
        send_word(32'h0F1E2D3C);
        rx_expect(16, ir, fc);
        @(negedge clk);
        bus.tx_start = 1'b1;
        bus.tx_Data  = 32'hDEADBEEF;
        @(negedge clk);
        bus.tx_start = 1'b0;
        for (int i = 1; i < 4; i++) rx_expect(16, ir, fc);
        wait_done();
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check("no queued word", bad, 0);
        check("done count ignored start", done_cnt - d0, 1);

        // back-to-back: start asserted in the tx_done cycle
        d0 = done_cnt;
        send_word(32'h3C3C3C3C);
        for (int i = 0; i < 4; i++) rx_expect(16, ir, fc);
        wait_done();
        bus.tx_start = 1'b1;
        bus.tx_Data  = 32'h00000001;
        for (int i = 0; i < 4; i++) exp_q.push_back((i == 0) ? 8'h01 : 8'h00);
        done_c = cyc;
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_Data  = $urandom;
        rx_expect(16, ir, fc);
        check("back-to-back start gap", fc - done_c, 2);
        for (int i = 1; i < 4; i++) rx_expect(16, ir, fc);
        wait_done();
        repeat (5) @(negedge clk);
        check("done count back-to-back", done_cnt - d0, 2);

        // reset during the third byte's data bits
        d0 = done_cnt;
        send_word(32'h1100FF22);
        rx_expect(16, ir, fc);
        rx_expect(16, ir, fc);
        exp_q.delete();
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < 400);
        repeat (72) @(negedge clk);
        check("line low in byte2 data", {31'd0, tx}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async reset tx high", {31'd0, tx}, 32'd1);
        check("async reset busy low", {31'd0, bus.tx_busy}, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check("idle after reset", bad, 0);
        check("no done after reset", done_cnt - d0, 0);

        d0 = done_cnt;
        send_word(32'hCAFEBABE);
        for (int i = 0; i < 4; i++) rx_expect(16, ir, fc);
        wait_done();
        repeat (5) @(negedge clk);
        check("done count after reset", done_cnt - d0, 1);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Responder end of the debug controller's transmit handshake.
- Accepts a 32-bit word on `tx_start`/`tx_Data` and serialises it as NBITS/8 bytes, least-significant byte first.
- Each byte goes out as an 8N1 UART frame on the serial line, timed by an oversampled baud tick from the shared baud generator.
- Pulses `tx_done` once the whole word has left the line.
- Sits between the debug controller and the board TX pin, mirroring the receive-side word assembler.

Parameters:
- NBITS, 32, width of the word accepted per transfer; must be a multiple of DBIT.
- DBIT, 8, data bits per UART frame.
- SB_TICK, 16, `s_tick` pulses per stop bit.
- OVERSAMPLE, 16, `s_tick` pulses per start or data bit.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_tick  in  1  baud-rate x OVERSAMPLE enable pulse, one clk wide.
- tx_start  in  1  request to send `tx_Data`; sampled only when idle.
- tx_Data  in  NBITS  word to transmit; captured on accept.
- tx_done  out  1  one-cycle pulse: whole word transmitted.
- tx_busy  out  1  high from the accept cycle until `tx_done`.
- tx  out  1  serial line; idles high.

Behaviour:
- Reset (rst=0, async): state IDLE, `tx`=1, `tx_done`=0, `tx_busy`=0, tick/bit/byte counters 0, shift register 0.
- Reset mid-frame aborts immediately: line forced high, no `tx_done`.
- Word FSM, states:
  - IDLE: `tx_start`=1 latches `tx_Data` into the word register, clears the byte counter and goes to SEND; `tx_busy` is registered high from the next edge.
  - SEND: loads byte[byte_cnt] (bits 8k+7:8k) into the byte serialiser and pulses its start; goes to WAIT.
  - WAIT: on the serialiser's byte-done, increments byte_cnt. If byte_cnt was NBITS/DBIT-1, goes to IDLE and registers `tx_done`=1; otherwise returns to SEND.
- Byte serialiser FSM (per frame):
  - START: `tx`=0 for OVERSAMPLE ticks.
  - DATA: DBIT bits LSB-first, OVERSAMPLE ticks each, shifted right.
  - STOP: `tx`=1 for SB_TICK ticks, then byte-done pulse.
  - The tick counter advances only on `s_tick`; a state/bit advances on the `s_tick` where count==limit-1, and the count wraps to 0.
- Gap between consecutive bytes of one word is 2 clk (SEND plus start load); there are no extra idle ticks on the line beyond the stop bit.
- Registered `tx` output has no glitches; `tx` changes only on clk edges.
- `tx_done`: high exactly one clk, in the first IDLE cycle; `tx_busy` is 0 in that same cycle.
- `tx_start` in the `tx_done` cycle is accepted (back-to-back words).
- `tx_start` while busy is ignored; it is not queued.
- `tx_Data` may change freely after the accept edge.
- `s_tick` is allowed every cycle (tied high in sim); the ideal word duration is then NBITS/DBIT*(1+DBIT)*OVERSAMPLE + SB_TICK*NBITS/DBIT ticks = 640 for the defaults.
- Any per-byte clk overhead adds no ticks, because the tick count restarts on each byte start.
- Coincident `s_tick` and state change: the new state's counter starts at 0 and that tick is not counted twice.

Decomposition:
- Shared package `uart_pkg`: word-FSM and byte-FSM state encodings, BYTES_PER_WORD = NBITS/DBIT, and the default DBIT/OVERSAMPLE/SB_TICK constants shared with the receive-side word assembler.
- One sub-module, `uart_tx_byte`: an 8N1 serialiser with `s_tick`, `byte_start`, `byte_in`, `byte_done` and `tx`, also reusable standalone.
- The top level contains the word FSM, byte counter, word register and output registers.

Test Plan:
- Reset release, no request: `tx`=1, `tx_busy`=0, `tx_done`=0 for 1000 cycles.
- `s_tick` tied 1, `tx_start` for one cycle with `tx_Data`=0x12345678:
  - line decodes to bytes 0x78, 0x56, 0x34, 0x12, each with start=0 and stop=1, bit period 16 clk;
  - `tx_done` pulses once, `tx_busy` drops in the same cycle.
- `tx_Data`=0xA5C3FF00 with `s_tick` every 4 clk: decoded bytes 0x00, 0xFF, 0xC3, 0xA5; bit period exactly 64 clk.
- `tx_start` re-asserted with 0xDEADBEEF mid-word: ignored; the original word is sent intact and only one `tx_done` occurs.
- `tx_start` held in the `tx_done` cycle with 0x00000001: the second word's start bit follows the first word's last stop bit with no idle bit time; first decoded byte is 0x01.
- rst pulsed low during the third byte's data bits:
  - `tx`=1 asynchronously, no `tx_done`;
  - after release, a new word 0xCAFEBABE transmits correctly.
